lsu: RTL

Load/store unit in the execute-to-memory path. Consumes the effective address produced by the ALU (op1+op2 with aluctrl 4'b0000) along with the store data and funct3 of the memory instruction. Drives a single-outstanding request/grant/rvalid data-memory port and returns aligned, sign- or zero-extended load data to writeback. Stalls the pipeline through a valid/ready handshake while an access is in flight.

---
 rtl/lsu_pkg.sv | 27 ++
 rtl/lsu_if.sv | 24 ++
 rtl/lsu_align.sv | 68 ++++++
 rtl/lsu.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: funct3 width codes, FSM states and
// the latched memory-op record.
package lsu_pkg;

  localparam int LSU_XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } lsu_state_t;

  typedef struct packed {
    logic                is_load;
    logic [2:0]          funct3;
    logic [LSU_XLEN-1:0] addr;
    logic [LSU_XLEN-1:0] wdata;
    logic [4:0]          rd;
  } ldst_op_t;

endpackage

// File: rtl/lsu_if.sv
// Single-outstanding request/grant/rvalid data-memory port.
interface lsu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store-side enables/replication/legality checks and
// load-side shift plus sign/zero extension.
module lsu_align import lsu_pkg::*; (
  input  logic                st_is_load,
  input  logic [2:0]          st_funct3,
  input  logic [1:0]          st_addr_lo,
  input  logic [LSU_XLEN-1:0] st_wdata,
  output logic [3:0]          st_be,
  output logic [LSU_XLEN-1:0] st_lane,
  output logic                st_misaligned,
  output logic                st_illegal,
  input  logic [2:0]          ld_funct3,
  input  logic [1:0]          ld_addr_lo,
  input  logic [LSU_XLEN-1:0] ld_rdata,
  output logic [LSU_XLEN-1:0] ld_data
);

  logic [LSU_XLEN-1:0] ld_shift_s;

  assign ld_shift_s = ld_rdata >> {ld_addr_lo, 3'b000};

  // Access size comes from funct3[1:0]; legality also depends on load vs store
  always_comb begin
    st_be         = 4'b0000;
    st_lane       = {LSU_XLEN{1'b0}};
    st_misaligned = 1'b0;
    case (st_funct3[1:0])
      2'b00: begin
        st_be   = 4'b0001 << st_addr_lo;
        st_lane = {4{st_wdata[7:0]}};
      end
      2'b01: begin
        st_be         = 4'b0011 << {st_addr_lo[1], 1'b0};
        st_lane       = {2{st_wdata[15:0]}};
        st_misaligned = st_addr_lo[0];
      end
      2'b10: begin
        st_be         = 4'b1111;
        st_lane       = st_wdata;
        st_misaligned = |st_addr_lo;
      end
      default: begin
        st_be         = 4'b0000;
        st_lane       = {LSU_XLEN{1'b0}};
        st_misaligned = 1'b0;
      end
    endcase

    case (st_funct3)
      F3_B, F3_H, F3_W: st_illegal = 1'b0;
      F3_BU, F3_HU:     st_illegal = !st_is_load;
      default:          st_illegal = 1'b1;
    endcase
  end

  // Load result extension
  always_comb begin
    case (ld_funct3)
      F3_B:    ld_data = {{24{ld_shift_s[7]}}, ld_shift_s[7:0]};
      F3_H:    ld_data = {{16{ld_shift_s[15]}}, ld_shift_s[15:0]};
      F3_W:    ld_data = ld_shift_s;
      F3_BU:   ld_data = {24'h00_0000, ld_shift_s[7:0]};
      F3_HU:   ld_data = {16'h0000, ld_shift_s[15:0]};
      default: ld_data = {LSU_XLEN{1'b0}};
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one memory op at a time from execute, runs it on
// the data-memory port and returns extended load data to writeback.
module lsu import lsu_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_is_load,
  input  logic              ex_is_store,
  input  logic [2:0]        ex_funct3,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic [4:0]        ex_rd,
  input  logic              flush,
  lsu_if.master             mem,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              fault,
  output logic [ADDR_W-1:0] fault_addr
);

  lsu_state_t          state_r;
  ldst_op_t            op_r;
  logic                drop_r;
  logic                mem_req_r;
  logic                mem_we_r;
  logic [3:0]          mem_be_r;
  logic                wb_valid_r;
  logic [4:0]          wb_rd_r;
  logic [DATA_W-1:0]   wb_data_r;
  logic                fault_r;
  logic [ADDR_W-1:0]   fault_addr_r;

  logic [3:0]          st_be_s;
  logic [LSU_XLEN-1:0] st_lane_s;
  logic                st_misaligned_s;
  logic                st_illegal_s;
  logic [LSU_XLEN-1:0] ld_data_s;
  logic                is_mem_s;
  logic                bad_op_s;

  lsu_align u_align (
    .st_is_load    (ex_is_load),
    .st_funct3     (ex_funct3),
    .st_addr_lo    (ex_addr[1:0]),
    .st_wdata      (ex_wdata),
    .st_be         (st_be_s),
    .st_lane       (st_lane_s),
    .st_misaligned (st_misaligned_s),
    .st_illegal    (st_illegal_s),
    .ld_funct3     (op_r.funct3),
    .ld_addr_lo    (op_r.addr[1:0]),
    .ld_rdata      (mem.mem_rdata),
    .ld_data       (ld_data_s)
  );

  assign is_mem_s = ex_is_load || ex_is_store;
  assign bad_op_s = (ex_is_load && ex_is_store) || st_illegal_s || st_misaligned_s;

  assign ex_ready       = (state_r == IDLE);
  assign mem.mem_req    = mem_req_r;
  assign mem.mem_we     = mem_we_r;
  assign mem.mem_be     = mem_be_r;
  assign mem.mem_addr   = {op_r.addr[LSU_XLEN-1:2], 2'b00};
  assign mem.mem_wdata  = op_r.wdata;
  assign wb_valid       = wb_valid_r;
  assign wb_rd          = wb_rd_r;
  assign wb_data        = wb_data_r;
  assign fault          = fault_r;
  assign fault_addr     = fault_addr_r;

  // Op sequencing: accept/fault in IDLE, request until grant, await load data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      op_r         <= '{is_load: 1'b0, funct3: 3'b000, addr: {LSU_XLEN{1'b0}},
                        wdata: {LSU_XLEN{1'b0}}, rd: 5'd0};
      drop_r       <= 1'b0;
      mem_req_r    <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_be_r     <= 4'b0000;
      wb_valid_r   <= 1'b0;
      wb_rd_r      <= 5'd0;
      wb_data_r    <= {DATA_W{1'b0}};
      fault_r      <= 1'b0;
      fault_addr_r <= {ADDR_W{1'b0}};
    end else begin
      wb_valid_r <= 1'b0;
      fault_r    <= 1'b0;
      case (state_r)
        IDLE: begin
          if (ex_valid && is_mem_s) begin
            if (bad_op_s) begin
              fault_r      <= 1'b1;
              fault_addr_r <= ex_addr;
            end else begin
              op_r.is_load <= ex_is_load;
              op_r.funct3  <= ex_funct3;
              op_r.addr    <= ex_addr;
              op_r.wdata   <= ex_is_store ? st_lane_s : {LSU_XLEN{1'b0}};
              op_r.rd      <= ex_rd;
              mem_req_r    <= 1'b1;
              mem_we_r     <= ex_is_store;
              mem_be_r     <= st_be_s;
              drop_r       <= 1'b0;
              state_r      <= REQ;
            end
          end
        end
        REQ: begin
          // A grant in the same cycle as flush still commits the access
          if (mem.mem_gnt) begin
            mem_req_r <= 1'b0;
            if (op_r.is_load) begin
              drop_r  <= flush;
              state_r <= WAIT;
            end else begin
              state_r <= IDLE;
            end
          end else if (flush) begin
            mem_req_r <= 1'b0;
            state_r   <= IDLE;
          end
        end
        WAIT: begin
          if (mem.mem_rvalid) begin
            if (!(drop_r || flush)) begin
              wb_valid_r <= 1'b1;
              wb_rd_r    <= op_r.rd;
              wb_data_r  <= ld_data_s;
            end
            drop_r  <= 1'b0;
            state_r <= IDLE;
          end else if (flush) begin
            drop_r <= 1'b1;
          end
        end
        default: begin
          mem_req_r <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule
